// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: IF/ID register owner, PC/bubble control, halt drain sequencing and stall/flush counters.
module pipeline_stall_controller #(
    parameter int          DRAIN_CYCLES = 2,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] NOP_INST     = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_stall,
    input  logic             ex_flush,
    input  logic             ex_halt,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    output logic             pc_write,
    output logic             id_ex_bubble,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             is_halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int DW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          eff_stall;
    logic          run;
    assign eff_stall    = is_stall & id_valid;
    assign run          = !reset && state == RUN;
    assign pc_write     = run && !ex_halt && (ex_flush || !eff_stall);
    assign id_ex_bubble = !run || ex_halt || ex_flush || eff_stall;
    // A flush discards any concurrent stall; halt outranks both and freezes the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            is_halted    <= 1'b0;
            id_pc        <= '0;
            id_inst      <= NOP_INST;
            id_valid     <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_halt) begin
                        id_pc     <= '0;
                        id_inst   <= NOP_INST;
                        id_valid  <= 1'b0;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                        state     <= DRAIN;
                    end else if (ex_flush) begin
                        id_pc    <= '0;
                        id_inst  <= NOP_INST;
                        id_valid <= 1'b0;
                        if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
                    end else if (eff_stall) begin
                        if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
                    end else begin
                        id_pc    <= if_pc;
                        id_inst  <= if_inst;
                        id_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state     <= HALTED;
                        is_halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: queue scoreboard against a cycle-indexed reference model of the stall controller.
module tb_pipeline_stall_controller;
    localparam int          DRAIN = 2;
    localparam int          CW    = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    typedef struct {
        logic          pw;
        logic          bb;
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic          v;
        logic          h;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          is_stall = 1'b0;
    logic          ex_flush = 1'b0;
    logic          ex_halt = 1'b0;
    logic [31:0]   if_pc = '0;
    logic [31:0]   if_inst = '0;
    logic          pc_write;
    logic          id_ex_bubble;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic          id_valid;
    logic          is_halted;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    exp_t          q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            edge_n = 0;
    int            halt_edge = -1;
    logic [31:0]   m_pc = '0;
    logic [31:0]   m_inst = NOP;
    logic          m_valid = 1'b0;
    int            m_sc = 0;
    int            m_fc = 0;

    pipeline_stall_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .is_stall(is_stall), .ex_flush(ex_flush), .ex_halt(ex_halt),
        .if_pc(if_pc), .if_inst(if_inst), .pc_write(pc_write), .id_ex_bubble(id_ex_bubble),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .is_halted(is_halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge-time %0t: got %h, expected %h", name, $time, act, exp);
    endfunction

    // Model tracks drain by edge arithmetic: halted once DRAIN+1 edges have passed since the halt edge.
    task automatic drive(input bit r, input bit s, input bit f, input bit h,
                         input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        bit   run;
        bit   es;
        @(negedge clk);
        reset = r; is_stall = s; ex_flush = f; ex_halt = h; if_pc = pc; if_inst = inst;
        run  = !r && halt_edge < 0;
        es   = s && m_valid;
        e.pw = run && !h && (f || !es);
        e.bb = !run || h || f || es;
        if (r) begin
            m_pc = '0; m_inst = NOP; m_valid = 1'b0; m_sc = 0; m_fc = 0; halt_edge = -1;
        end else if (run) begin
            if (h) begin
                halt_edge = edge_n; m_pc = '0; m_inst = NOP; m_valid = 1'b0;
            end else if (f) begin
                m_pc = '0; m_inst = NOP; m_valid = 1'b0; m_fc = (m_fc == 15) ? 15 : m_fc + 1;
            end else if (es) begin
                m_sc = (m_sc == 15) ? 15 : m_sc + 1;
            end else begin
                m_pc = pc; m_inst = inst; m_valid = 1'b1;
            end
        end
        e.h    = halt_edge >= 0 && edge_n >= halt_edge + DRAIN + 1;
        e.pc   = m_pc;
        e.inst = m_inst;
        e.v    = m_valid;
        e.sc   = CW'(m_sc);
        e.fc   = CW'(m_fc);
        q.push_back(e);
        edge_n++;
    endtask

    task automatic normal(input logic [31:0] pc);
        drive(0, 0, 0, 0, pc, $urandom);
    endtask

    initial begin : monitor
        logic cpw, cbb;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cpw = pc_write;
            cbb = id_ex_bubble;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pc_write", 32'(cpw), 32'(e.pw));
                check("id_ex_bubble", 32'(cbb), 32'(e.bb));
                check("id_pc", id_pc, e.pc);
                check("id_inst", id_inst, e.inst);
                check("id_valid", 32'(id_valid), 32'(e.v));
                check("is_halted", 32'(is_halted), 32'(e.h));
                check("stall_cycles", 32'(stall_cycles), 32'(e.sc));
                check("flush_count", 32'(flush_count), 32'(e.fc));
            end
        end
    end

    initial begin : stimulus
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        normal(32'h0); normal(32'h4); normal(32'h8);
        drive(0, 1, 0, 0, 32'hC, 32'hDEAD0001);
        drive(0, 1, 0, 0, 32'hC, 32'hDEAD0001);
        normal(32'hC);
        drive(0, 1, 1, 0, 32'h10, 32'h11111111);
        drive(0, 1, 0, 0, 32'h40, 32'h22222222);
        normal(32'h44); normal(32'h48);
        drive(0, 0, 1, 1, 32'h4C, 32'h33333333);
        for (int i = 0; i < 6; i++) drive(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        drive(1, 0, 0, 0, 0, 0);
        normal(32'h100); normal(32'h104);
        drive(0, 0, 0, 1, 32'h108, 32'h1);
        drive(0, 1, 1, 0, 32'h10C, 32'h2);
        drive(1, 0, 0, 0, 0, 0);
        normal(32'h200);
        for (int i = 0; i < 17; i++) drive(0, 1, 0, 0, 32'h204, 32'h5);
        normal(32'h204);
        for (int i = 0; i < 20; i++) drive(0, 1'($urandom), 1, 0, $urandom, $urandom);
        for (int i = 0; i < 500; i++)
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 3, {$urandom_range(0, 1023), 2'b00}, $urandom);
        @(posedge clk);
        #3;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
